// File: rtl/glb_opsum_drain.sv
// glb_opsum_drain
//   Walks the opsum region of the GLB after a pass and streams each word out
//   on a valid/ready port. Owns the GLB read port while draining. A 1-bit
//   inflight flag tracks the single outstanding read. A 2-entry buffer absorbs
//   the 1-cycle read latency, so back-pressure never drops a word.
//
//   Optional feature macro: GLB_DRAIN_RELU_EN. When defined, negative words are
//   clamped to zero as they arrive from the GLB. When undefined, words pass
//   through unchanged.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   start         one-cycle drain request, honoured only when idle
//   base_addr     byte address of first word (word aligned), latched on start
//   num_words     words to drain, latched on start
//   busy          high while reading/flushing
//   done          one-cycle pulse after the final beat is accepted
//   glb_re        4'b1111 in cycles that issue a read, else 0
//   glb_r_addr    read byte address; holds the last issued address otherwise
//   glb_r_data    GLB read data, valid the cycle after glb_re
//   out_valid     out_data holds a valid word
//   out_ready     consumer accepts the word this cycle
//   out_data      drained word (0 when nothing is valid)
//   out_last      marks the final word of the drain
//
// Handshake: a beat transfers in every cycle where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_valid and out_data hold.
module glb_opsum_drain #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_BITS = 32,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [CNT_BITS-1:0]  num_words,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           glb_re,
  output logic [ADDR_BITS-1:0] glb_r_addr,
  input  logic [DATA_SIZE-1:0] glb_r_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]           state;
  logic [ADDR_BITS-1:0] addr;
  logic [ADDR_BITS-1:0] last_addr;
  logic [CNT_BITS-1:0]  issue_cnt;
  logic [CNT_BITS-1:0]  beat_cnt;
  logic                 inflight;
  logic [DATA_SIZE-1:0] buf_mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           buf_count;

  logic [1:0]           occ;
  logic                 issue;
  logic                 pop;
  logic                 pop_buf;
  logic                 push;
  logic [DATA_SIZE-1:0] in_word;

`ifdef GLB_DRAIN_RELU_EN
  assign in_word = glb_r_data[DATA_SIZE-1] ? '0 : glb_r_data;
`else
  assign in_word = glb_r_data;
`endif

  // Buffered words plus the word arriving this cycle. A new read is only
  // issued when a slot is guaranteed for its data next cycle.
  assign occ   = buf_count + {1'b0, inflight};
  assign issue = (state == S_READ) && (occ < 2'd2);

  // An arriving word is presented directly when the buffer is empty; if it
  // is accepted in that same cycle it never needs a buffer slot. Otherwise it
  // is stored, so the word shown while stalled stays the same next cycle.
  assign out_valid = (buf_count != 2'd0) || inflight;
  assign out_data  = (buf_count != 2'd0) ? buf_mem[rd_ptr] :
                     (inflight ? in_word : '0);
  assign pop       = out_valid && out_ready;
  assign pop_buf   = pop && (buf_count != 2'd0);
  assign push      = inflight && !(pop && (buf_count == 2'd0));
  assign out_last  = out_valid && (beat_cnt == CNT_BITS'(1));

  assign glb_re     = issue ? 4'b1111 : 4'b0000;
  assign glb_r_addr = issue ? addr : last_addr;
  assign busy       = (state == S_READ) || (state == S_FLUSH);
  assign done       = (state == S_FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      last_addr  <= '0;
      issue_cnt  <= '0;
      beat_cnt   <= '0;
      inflight   <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      buf_count  <= 2'd0;
    end else begin
      inflight <= issue;

      if (push) begin
        buf_mem[wr_ptr] <= in_word;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop_buf) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop_buf})
        2'b10:   buf_count <= buf_count + 2'd1;
        2'b01:   buf_count <= buf_count - 2'd1;
        default: buf_count <= buf_count;
      endcase

      if (pop) begin
        beat_cnt <= beat_cnt - CNT_BITS'(1);
      end

      if (issue) begin
        addr      <= addr + ADDR_BITS'(4);
        last_addr <= addr;
        issue_cnt <= issue_cnt - CNT_BITS'(1);
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= base_addr;
            issue_cnt <= num_words;
            beat_cnt  <= num_words;
            state     <= (num_words == '0) ? S_FIN : S_READ;
          end
        end
        S_READ: begin
          if (issue && (issue_cnt == CNT_BITS'(1))) begin
            state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // Leave as soon as the final beat is accepted so done follows it
          // by exactly one cycle.
          if ((beat_cnt == '0) || (pop && (beat_cnt == CNT_BITS'(1)))) begin
            state <= S_FIN;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glb_opsum_drain.sv
module tb_glb_opsum_drain;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic        busy, done, out_valid, out_last;
  logic        out_ready = 1'b0;
  logic [3:0]  glb_re;
  logic [31:0] glb_r_addr, out_data;
  logic [31:0] glb_r_data = '0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  glb_opsum_drain #(.DATA_SIZE(32), .ADDR_BITS(32), .CNT_BITS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .glb_re(glb_re),
    .glb_r_addr(glb_r_addr), .glb_r_data(glb_r_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  // ---------------- GLB memory model ----------------
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] glb_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], 16'h5A3C};
  endfunction

  function automatic logic [31:0] relu(input logic [31:0] w);
`ifdef GLB_DRAIN_RELU_EN
    return w[31] ? 32'h0 : w;
`else
    return w;
`endif
  endfunction

  always @(posedge clk) if (glb_re != 4'h0) glb_r_data <= glb_word(glb_r_addr);

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  int          log_read_cyc[$];
  logic [31:0] log_read_addr[$];
  int          log_beat_cyc[$];
  logic [31:0] log_beat_data[$];
  int          log_done_cyc[$];

  bit          armed = 0;
  bit          exp_busy = 0;
  bit          exp_done = 0;
  bit          chk_rst_out = 0;
  bit          stalled = 0;
  logic [31:0] held_data = '0;
  int          issued = 0;
  int          accepted = 0;

  // Drain model: a drain is a list of addresses to read and the words they
  // must produce. busy spans start+1 up to the final accepted beat, and done
  // is the cycle after it (or after start for an empty drain).
  always @(negedge clk) begin
    bit acc;
    acc = out_valid && out_ready;
    if (armed) begin
      if (chk_rst_out) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_glb_re", glb_re, 0);
        chk("rst_glb_r_addr", glb_r_addr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
      end
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      if (done) log_done_cyc.push_back(cyc);
      if (glb_re != 4'h0) begin
        chk("glb_re_mask", glb_re, 4'hF);
        if (exp_addr_q.size() == 0) chk("read_unexpected", 1, 0);
        else chk("glb_r_addr", glb_r_addr, exp_addr_q.pop_front());
        issued++;
        chk("outstanding_le_2", (issued - accepted) <= 2, 1);
        log_read_cyc.push_back(cyc);
        log_read_addr.push_back(glb_r_addr);
      end
      if (!exp_busy) chk("valid_while_idle", out_valid, 0);
      if (stalled) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held_data);
      end
      if (out_valid && exp_busy) begin
        if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          chk("out_data", out_data, exp_q[0]);
          chk("out_last", out_last, exp_q.size() == 1);
        end
      end
    end
    stalled = out_valid && !out_ready;
    held_data = out_data;
    chk_rst_out = 0;
    if (rst) begin
      armed = 1;
      exp_busy = 0;
      exp_done = 0;
      exp_q.delete();
      exp_addr_q.delete();
      chk_rst_out = 1;
      stalled = 0;
    end else if (!exp_busy && !exp_done && start) begin
      issued = 0;
      accepted = 0;
      for (int i = 0; i < int'(num_words); i++) begin
        logic [31:0] a;
        a = base_addr + 32'(4 * i);
        exp_addr_q.push_back(a);
        exp_q.push_back(relu(glb_word(a)));
      end
      if (num_words == 0) exp_done = 1;
      else exp_busy = 1;
    end else if (exp_busy) begin
      exp_done = 0;
      if (acc && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        accepted++;
        log_beat_cyc.push_back(cyc);
        log_beat_data.push_back(out_data);
        if (exp_q.size() == 0) begin
          exp_busy = 0;
          exp_done = 1;
        end
      end
    end else begin
      exp_done = 0;
    end
  end

  // ---------------- driver tasks ----------------
  int ready_mode = 0; // 0: always ready, 1: random, 2: stalled

  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 9) < 7);
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] n, output int s);
    base_addr = b;
    num_words = n;
    start = 1'b1;
    s = cyc;
    step();
    base_addr = $urandom;
    num_words = 16'($urandom);
  endtask

  task automatic wait_done(input int budget, input bit noise);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      step();
      if (noise && busy && $urandom_range(0, 7) == 0) start = 1'b1;
    end
    if (!got) chk("done_timeout", 0, 1);
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s, rb, bb, db, v;
    bit got;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Directed: 4 words, always ready, exact cycle timing.
    for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'(i + 1);
    ready_mode = 0;
    rb = log_read_cyc.size(); bb = log_beat_cyc.size(); db = log_done_cyc.size();
    do_start(32'h100, 16'd4, s);
    wait_done(50, 0);
    chk("t1_reads", log_read_cyc.size() - rb, 4);
    chk("t1_beats", log_beat_cyc.size() - bb, 4);
    chk("t1_dones", log_done_cyc.size() - db, 1);
    if (log_read_cyc.size() - rb == 4 && log_beat_cyc.size() - bb == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_read_cyc", log_read_cyc[rb + i], s + 1 + i);
        chk("t1_read_addr", log_read_addr[rb + i], 32'h100 + 32'(4 * i));
        chk("t1_beat_cyc", log_beat_cyc[bb + i], s + 2 + i);
        chk("t1_beat_data", log_beat_data[bb + i], 32'(i + 1));
      end
    end
    if (log_done_cyc.size() - db == 1) chk("t1_done_cyc", log_done_cyc[db], s + 6);

    // Directed: stall for 5 cycles after first out_valid.
    ready_mode = 2;
    step();
    rb = log_read_cyc.size(); bb = log_beat_cyc.size();
    do_start(32'h100, 16'd4, s);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin got = 1; break; end
      step();
    end
    chk("t2_first_valid_seen", got, 1);
    v = cyc;
    chk("t2_first_valid_cyc", v, s + 2);
    repeat (4) step();
    chk("t2_held_data", out_data, 32'h1);
    ready_mode = 0;
    step();
    chk("t2_reads_during_stall", log_read_cyc.size() - rb, 2);
    wait_done(50, 0);
    chk("t2_beats", log_beat_cyc.size() - bb, 4);
    if (log_beat_cyc.size() - bb == 4)
      for (int i = 0; i < 4; i++) chk("t2_beat_data", log_beat_data[bb + i], 32'(i + 1));

    // Directed: empty drain.
    rb = log_read_cyc.size(); bb = log_beat_cyc.size(); db = log_done_cyc.size();
    do_start(32'h300, 16'd0, s);
    wait_done(10, 0);
    chk("t3_reads", log_read_cyc.size() - rb, 0);
    chk("t3_beats", log_beat_cyc.size() - bb, 0);
    chk("t3_dones", log_done_cyc.size() - db, 1);
    if (log_done_cyc.size() - db == 1) chk("t3_done_cyc", log_done_cyc[db], s + 1);

    // Directed: second start during an 8-word drain is ignored.
    ready_mode = 1;
    bb = log_beat_cyc.size(); db = log_done_cyc.size();
    do_start(32'h400, 16'd8, s);
    step();
    base_addr = 32'h800; num_words = 16'd3; start = 1'b1;
    step();
    wait_done(200, 0);
    chk("t4_beats", log_beat_cyc.size() - bb, 8);
    chk("t4_dones", log_done_cyc.size() - db, 1);

    // Directed: reset after 3 of 8 beats, then a fresh 2-word drain.
    ready_mode = 0;
    bb = log_beat_cyc.size(); db = log_done_cyc.size();
    do_start(32'h500, 16'd8, s);
    got = 0;
    for (int i = 0; i < 30; i++) begin
      if (log_beat_cyc.size() - bb >= 3) begin got = 1; break; end
      step();
    end
    chk("t5_three_beats", got, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (12) step();
    chk("t5_no_done", log_done_cyc.size() - db, 0);
    mem[32'h600] = 32'hAA;
    mem[32'h604] = 32'hBB;
    bb = log_beat_cyc.size();
    do_start(32'h600, 16'd2, s);
    wait_done(20, 0);
    chk("t5_beats", log_beat_cyc.size() - bb, 2);
    if (log_beat_cyc.size() - bb == 2) begin
      chk("t5_beat0", log_beat_data[bb], 32'hAA);
      chk("t5_beat1", log_beat_data[bb + 1], 32'hBB);
    end

    // Directed: negative word handling.
    mem[32'h700] = 32'hFFFF_FFF6;
    mem[32'h704] = 32'h0000_0007;
    bb = log_beat_cyc.size();
    do_start(32'h700, 16'd2, s);
    wait_done(20, 0);
    if (log_beat_cyc.size() - bb == 2) begin
`ifdef GLB_DRAIN_RELU_EN
      chk("t6_beat0", log_beat_data[bb], 32'h0);
`else
      chk("t6_beat0", log_beat_data[bb], 32'hFFFF_FFF6);
`endif
      chk("t6_beat1", log_beat_data[bb + 1], 32'h7);
    end else chk("t6_beats", log_beat_cyc.size() - bb, 2);

    // Random drains with random back-pressure, spurious starts and wrap.
    ready_mode = 1;
    for (int it = 0; it < 30; it++) begin
      logic [31:0] b;
      logic [15:0] n;
      b = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3)))
                                      : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      n = 16'($urandom_range(0, 12));
      for (int i = 0; i < int'(n); i++) mem[b + 32'(4 * i)] = $urandom;
      db = log_done_cyc.size();
      do_start(b, n, s);
      wait_done(400, 1);
      chk("rand_one_done", log_done_cyc.size() - db, 1);
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/glb_opsum_drain.md
Name: glb_opsum_drain

Overview:
Read-side counterpart to the pass controller's opsum write path into the GLB. After a pass finishes, this block walks the opsum region of the GLB and streams each 32-bit word out on a valid/ready interface to the host/testbench side. It owns the GLB read port (re/r_addr/dout) while active and absorbs the GLB's 1-cycle read latency with a 2-entry output buffer, so back-pressure never loses data.

Parameters:
DATA_SIZE, 32, width of a GLB word and of out_data
ADDR_BITS, 32, width of GLB byte addresses
CNT_BITS, 16, width of the word-count input and internal counters

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  one-cycle request to begin a drain; sampled only in IDLE
base_addr  input  ADDR_BITS  byte address of first opsum word (word aligned)
num_words  input  CNT_BITS  number of words to drain; latched on start
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse after the final beat is accepted
glb_re  output  4  GLB read byte enables (4'b1111 when reading, else 0)
glb_r_addr  output  ADDR_BITS  GLB read byte address
glb_r_data  input  DATA_SIZE  GLB read data, valid the cycle after glb_re
out_valid  output  1  out_data holds a valid word
out_ready  input  1  consumer accepts the word when valid && ready
out_data  output  DATA_SIZE  drained word
out_last  output  1  high with the final word of the drain

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy, done, out_valid, out_last = 0; glb_re = 0; glb_r_addr = 0; out_data = 0; buffer empty; all counters 0. Reset mid-drain aborts immediately; no done pulse.
- FSM states: IDLE, READ, FLUSH, FIN.
- IDLE: on start, latch base_addr into addr, num_words into issue_cnt and beat_cnt. If num_words==0 go to FIN (no GLB reads, no beats). Else go to READ.
- READ: issue a read (glb_re=4'b1111, glb_r_addr=addr) when (buf_count + inflight) < 2. On issue: addr += 4, issue_cnt -= 1. When the last read is issued go to FLUSH.
- Read data is written into the buffer the cycle after issue (inflight is a 1-bit register). Reads are never issued without guaranteed buffer space.
- Buffer: 2-entry FIFO; out_valid = !empty; out_data = head entry. Pop on out_valid && out_ready. Push and pop in the same cycle is allowed at any occupancy, including full.
- out_valid/out_data remain stable while out_ready is low.
- out_last = out_valid && (beat_cnt==1). beat_cnt decrements on every accepted beat.
- FLUSH: no reads; wait until beat_cnt==0, then go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- busy = (state != IDLE) && (state != FIN).
- start while not in IDLE is ignored. base_addr/num_words changes after start have no effect.
- Throughput: with out_ready tied high, one word per cycle after a 2-cycle start-up (start -> first glb_re next cycle -> out_valid the cycle after that).
- Address wrap: addr increments modulo 2^ADDR_BITS; no error flag.
- glb_re is 0 in every cycle a read is not issued; glb_r_addr holds its last value.

Optional Feature:
GLB_DRAIN_RELU_EN: when defined, each word is treated as signed DATA_SIZE and clamped to 0 if negative as it enters the buffer (same cycle, no added latency). When undefined, words pass through unmodified. Handshake timing is identical either way.

Test Plan:
- GLB words 0x100..0x10C = 1,2,3,4; start with base_addr=0x100, num_words=4, out_ready=1 -> glb_r_addr 0x100,0x104,0x108,0x10C on consecutive cycles; out_data 1,2,3,4 on consecutive cycles; out_last with 4; done one cycle after the beat carrying 4.
- Same setup, out_ready low for 5 cycles after first out_valid -> at most 2 reads outstanding/buffered; glb_re low while full; out_data holds 1 stable; all 4 words delivered in order when ready rises.
- num_words=0 -> no glb_re assertion, no out_valid, done pulses the cycle after start.
- Second start pulse during drain of 8 words -> ignored; exactly 8 beats, one done.
- rst asserted after 3 of 8 beats -> next cycle all outputs 0, no done; a fresh start with num_words=2 drains correctly from the new base_addr.
- With GLB_DRAIN_RELU_EN, GLB words 0xFFFFFFF6 (-10) and 0x00000007 -> out_data 0x0 then 0x7; without the macro -> 0xFFFFFFF6 then 0x7.
